// File: rtl/piano_sequencer.sv
// Timed playback engine: queues {command, duration} events and issues each command
// onto the piano bus, holding for duration tempo ticks; stop flushes and silences all tracks.
module piano_sequencer #(
  parameter int FIFO_AW  = 4,
  parameter int TICK_DIV = 100000
) (
  input  logic               iFpgaClock,
  input  logic               iFpgaReset,
  input  logic               iPushValid,
  input  logic [15:0]        iPushEvent,
  output logic               oPushReady,
  input  logic               iStop,
  input  logic               iPause,
  output logic [7:0]         oPianoCommand,
  output logic               oBusy,
  output logic [FIFO_AW:0]   oFifoCount
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int TW    = $clog2(TICK_DIV);
  localparam logic [FIFO_AW:0] FULL_COUNT = (FIFO_AW + 1)'(DEPTH);
  localparam logic [TW-1:0]    TICK_MAX   = TW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    SILENCE
  } seqState;

  seqState            state, stateNext;
  logic [TW-1:0]      tickCount, tickNext;
  logic [7:0]         remaining, remainingNext;
  logic [1:0]         silIdx, silIdxNext;
  logic [7:0]         pianoCmd, pianoCmdNext;
  logic [FIFO_AW-1:0] wrPtr, wrPtrNext, rdPtr, rdPtrNext;
  logic [FIFO_AW:0]   count, countNext;
  logic               pushEn, popEn;
  logic [15:0]        headEvent;
  logic [15:0]        fifoMem [DEPTH];

  assign headEvent     = fifoMem[rdPtr];
  assign oPushReady    = (count != FULL_COUNT);
  assign oFifoCount    = count;
  assign oBusy         = (state != IDLE) || (count != '0);
  assign oPianoCommand = pianoCmd;

  // Event storage has no reset; validity is tracked by the pointers and count.
  always_ff @(posedge iFpgaClock) begin
    if (pushEn) begin
      fifoMem[wrPtr] <= iPushEvent;
    end
  end

  always_ff @(posedge iFpgaClock or posedge iFpgaReset) begin
    if (iFpgaReset) begin
      state     <= IDLE;
      tickCount <= '0;
      remaining <= '0;
      silIdx    <= '0;
      pianoCmd  <= 8'h00;
      wrPtr     <= '0;
      rdPtr     <= '0;
      count     <= '0;
    end else begin
      state     <= stateNext;
      tickCount <= tickNext;
      remaining <= remainingNext;
      silIdx    <= silIdxNext;
      pianoCmd  <= pianoCmdNext;
      wrPtr     <= wrPtrNext;
      rdPtr     <= rdPtrNext;
      count     <= countNext;
    end
  end

  // Stop overrides everything, including a same-cycle push and any pending pop.
  always_comb begin
    stateNext     = state;
    tickNext      = tickCount;
    remainingNext = remaining;
    silIdxNext    = silIdx;
    pianoCmdNext  = pianoCmd;
    wrPtrNext     = wrPtr;
    rdPtrNext     = rdPtr;
    countNext     = count;
    pushEn        = 1'b0;
    popEn         = 1'b0;

    if (iStop) begin
      stateNext     = SILENCE;
      silIdxNext    = '0;
      tickNext      = '0;
      remainingNext = '0;
      wrPtrNext     = '0;
      rdPtrNext     = '0;
      countNext     = '0;
    end else begin
      pushEn = iPushValid && (count != FULL_COUNT);

      case (state)
        IDLE: begin
          if ((count != '0) && !iPause) begin
            popEn        = 1'b1;
            pianoCmdNext = headEvent[15:8];
            if (headEvent[7:0] != 8'd0) begin
              stateNext     = WAIT;
              remainingNext = headEvent[7:0];
              tickNext      = '0;
            end
          end
        end
        WAIT: begin
          if (!iPause) begin
            if (tickCount == TICK_MAX) begin
              tickNext      = '0;
              remainingNext = remaining - 8'd1;
              if (remaining == 8'd1) begin
                stateNext = IDLE;
              end
            end else begin
              tickNext = tickCount + 1'b1;
            end
          end
        end
        SILENCE: begin
          pianoCmdNext = {silIdx, 6'b000000};
          if (silIdx == 2'd3) begin
            stateNext = IDLE;
          end else begin
            silIdxNext = silIdx + 2'd1;
          end
        end
        default: stateNext = IDLE;
      endcase

      if (pushEn) begin
        wrPtrNext = wrPtr + 1'b1;
      end
      if (popEn) begin
        rdPtrNext = rdPtr + 1'b1;
      end
      case ({pushEn, popEn})
        2'b10:   countNext = count + 1'b1;
        2'b01:   countNext = count - 1'b1;
        default: countNext = count;
      endcase
    end
  end

endmodule

// File: tb/tb_piano_sequencer.sv
// Directed self-checking bench for piano_sequencer with a short tempo tick and a 4-deep FIFO.
module tb_piano_sequencer;

  logic        iFpgaClock;
  logic        iFpgaReset;
  logic        iPushValid;
  logic [15:0] iPushEvent;
  logic        oPushReady;
  logic        iStop;
  logic        iPause;
  logic [7:0]  oPianoCommand;
  logic        oBusy;
  logic [2:0]  oFifoCount;

  int assertCount = 0;
  int failCount   = 0;

  piano_sequencer #(
    .FIFO_AW (2),
    .TICK_DIV(4)
  ) dut (
    .iFpgaClock   (iFpgaClock),
    .iFpgaReset   (iFpgaReset),
    .iPushValid   (iPushValid),
    .iPushEvent   (iPushEvent),
    .oPushReady   (oPushReady),
    .iStop        (iStop),
    .iPause       (iPause),
    .oPianoCommand(oPianoCommand),
    .oBusy        (oBusy),
    .oFifoCount   (oFifoCount)
  );

  initial iFpgaClock = 1'b0;
  always #5 iFpgaClock = ~iFpgaClock;

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  // One active edge, then settle so outputs are sampled away from the edge.
  task automatic applyStimulus(input int edges);
    for (int i = 0; i < edges; i++) begin
      @(posedge iFpgaClock);
      #1;
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_cmd"},   16'(oPianoCommand), 16'h0000);
    checkOutput({tag, "_busy"},  16'(oBusy),         16'h0000);
    checkOutput({tag, "_count"}, 16'(oFifoCount),    16'h0000);
    checkOutput({tag, "_ready"}, 16'(oPushReady),    16'h0001);
  endtask

  initial begin
    logic [15:0] pausedEvents [5];
    pausedEvents[0] = 16'h1100;
    pausedEvents[1] = 16'h2200;
    pausedEvents[2] = 16'h3300;
    pausedEvents[3] = 16'h4400;
    pausedEvents[4] = 16'h5500;

    iFpgaReset = 1'b1;
    iPushValid = 1'b0;
    iPushEvent = 16'h0000;
    iStop      = 1'b0;
    iPause     = 1'b0;
    applyStimulus(3);
    checkIdleOutputs("reset");
    iFpgaReset = 1'b0;
    applyStimulus(1);

    // Single event with duration 2: issued after edge 2, idle again after edge 10.
    iPushValid = 1'b1;
    iPushEvent = 16'h0502;
    applyStimulus(1);
    iPushValid = 1'b0;
    checkOutput("t1_count_after_push", 16'(oFifoCount), 16'd1);
    checkOutput("t1_cmd_not_yet", 16'(oPianoCommand), 16'h0000);
    applyStimulus(1);
    checkOutput("t1_cmd_issued", 16'(oPianoCommand), 16'h0005);
    checkOutput("t1_count_popped", 16'(oFifoCount), 16'd0);
    applyStimulus(7);
    checkOutput("t1_busy_edge9", 16'(oBusy), 16'd1);
    checkOutput("t1_cmd_hold", 16'(oPianoCommand), 16'h0005);
    applyStimulus(1);
    checkOutput("t1_idle_edge10", 16'(oBusy), 16'd0);

    // Chord: three back-to-back commands then one tick of wait.
    iPushValid = 1'b1;
    iPushEvent = 16'h0500;
    applyStimulus(1);
    checkOutput("t2_count1", 16'(oFifoCount), 16'd1);
    iPushEvent = 16'h4700;
    applyStimulus(1);
    checkOutput("t2_cmd05", 16'(oPianoCommand), 16'h0005);
    iPushEvent = 16'h8901;
    applyStimulus(1);
    checkOutput("t2_cmd47", 16'(oPianoCommand), 16'h0047);
    iPushValid = 1'b0;
    applyStimulus(1);
    checkOutput("t2_cmd89", 16'(oPianoCommand), 16'h0089);
    checkOutput("t2_count_empty", 16'(oFifoCount), 16'd0);
    applyStimulus(3);
    checkOutput("t2_busy_wait", 16'(oBusy), 16'd1);
    applyStimulus(1);
    checkOutput("t2_idle", 16'(oBusy), 16'd0);

    // Fill while paused: fourth push fills, fifth is dropped, then four issue in order.
    iPause     = 1'b1;
    iPushValid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      iPushEvent = pausedEvents[i];
      applyStimulus(1);
      if (i == 3) begin
        checkOutput("t3_count_full", 16'(oFifoCount), 16'd4);
        checkOutput("t3_ready_low", 16'(oPushReady), 16'd0);
      end
    end
    iPushValid = 1'b0;
    checkOutput("t3_count_after_drop", 16'(oFifoCount), 16'd4);
    checkOutput("t3_cmd_frozen", 16'(oPianoCommand), 16'h0089);
    iPause = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1);
      checkOutput($sformatf("t3_order%0d", i), 16'(oPianoCommand), 16'(pausedEvents[i][15:8]));
    end
    applyStimulus(1);
    checkOutput("t3_no_fifth", 16'(oPianoCommand), 16'h0044);
    checkOutput("t3_idle", 16'(oBusy), 16'd0);

    // Pause mid-wait: duration 3 (12 counting edges) plus 6 frozen edges.
    iPushValid = 1'b1;
    iPushEvent = 16'h1003;
    applyStimulus(1);
    iPushValid = 1'b0;
    applyStimulus(1);
    checkOutput("t4_cmd_issued", 16'(oPianoCommand), 16'h0010);
    applyStimulus(3);
    iPause = 1'b1;
    applyStimulus(6);
    checkOutput("t4_cmd_paused", 16'(oPianoCommand), 16'h0010);
    checkOutput("t4_busy_paused", 16'(oBusy), 16'd1);
    iPause = 1'b0;
    applyStimulus(8);
    checkOutput("t4_busy_edge17", 16'(oBusy), 16'd1);
    applyStimulus(1);
    checkOutput("t4_idle_edge18", 16'(oBusy), 16'd0);
    checkOutput("t4_cmd_held", 16'(oPianoCommand), 16'h0010);

    // Stop with one playing and three queued; a same-cycle push is dropped.
    iPushValid = 1'b1;
    iPushEvent = 16'h0102;
    applyStimulus(1);
    iPushEvent = 16'h0200;
    applyStimulus(1);
    checkOutput("t5_cmd_playing", 16'(oPianoCommand), 16'h0001);
    iPushEvent = 16'h0300;
    applyStimulus(1);
    iPushEvent = 16'h0400;
    applyStimulus(1);
    checkOutput("t5_count3", 16'(oFifoCount), 16'd3);
    iPushEvent = 16'h0600;
    iStop      = 1'b1;
    applyStimulus(1);
    iStop      = 1'b0;
    iPushValid = 1'b0;
    checkOutput("t5_flushed", 16'(oFifoCount), 16'd0);
    checkOutput("t5_cmd_before_silence", 16'(oPianoCommand), 16'h0001);
    checkOutput("t5_busy_silence", 16'(oBusy), 16'd1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1);
      checkOutput($sformatf("t5_silence%0d", i), 16'(oPianoCommand), 16'(i * 64));
    end
    checkOutput("t5_idle", 16'(oBusy), 16'd0);
    applyStimulus(1);
    checkOutput("t5_cmd_holds_c0", 16'(oPianoCommand), 16'h00C0);
    checkOutput("t5_still_empty", 16'(oFifoCount), 16'd0);

    // Asynchronous reset mid-wait, checked before any further clock edge.
    iPushValid = 1'b1;
    iPushEvent = 16'h2005;
    applyStimulus(1);
    iPushValid = 1'b0;
    applyStimulus(1);
    checkOutput("t6_cmd_playing", 16'(oPianoCommand), 16'h0020);
    applyStimulus(2);
    #2;
    iFpgaReset = 1'b1;
    #1;
    checkIdleOutputs("t6_async");
    applyStimulus(1);
    iFpgaReset = 1'b0;
    applyStimulus(1);
    iPushValid = 1'b1;
    iPushEvent = 16'h3000;
    applyStimulus(1);
    iPushValid = 1'b0;
    applyStimulus(1);
    checkOutput("t6_replay_cmd", 16'(oPianoCommand), 16'h0030);
    checkOutput("t6_replay_idle", 16'(oBusy), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/piano_sequencer.md
Name: piano_sequencer

Overview:
- Timed playback engine that drives the 8-bit piano command bus feeding the four-track note register block.
- The CPU (via MMIO) pushes 16-bit events {command[7:0], duration[7:0]} into an internal FIFO.
- The sequencer issues each command, then holds for `duration` tempo ticks before issuing the next. Duration 0 issues back-to-back, which forms chords across tracks.
- A stop request flushes pending events and silences all four tracks.

Parameters:
- FIFO_AW, 4: log2 of FIFO depth (depth 16).
- TICK_DIV, 100000: clock cycles per tempo tick (1 ms at 100 MHz); legal range ≥ 2.

Ports:
- iFpgaClock  in  1  system clock
- iFpgaReset  in  1  asynchronous reset, active-high
- iPushValid  in  1  event write strobe, one event per cycle
- iPushEvent  in  16  [15:8] piano command ({track[1:0], note[5:0]}), [7:0] duration in ticks
- oPushReady  out  1  FIFO not full
- iStop  in  1  single-cycle pulse: flush and silence
- iPause  in  1  level: freeze playback
- oPianoCommand  out  8  registered command to the track register block
- oBusy  out  1  state != IDLE or FIFO non-empty
- oFifoCount  out  FIFO_AW+1  number of queued events

Behaviour:
- Reset (asynchronous):
  - FIFO empty; oFifoCount=0; oPushReady=1.
  - State IDLE; tick counter=0; remaining=0.
  - oPianoCommand=8'h00; oBusy=0.
- FIFO:
  - A push is accepted on an edge where iPushValid && oPushReady.
  - A push while full is dropped silently; count is unchanged.
  - There is no full bypass: oPushReady = (count != depth) and does not anticipate a same-cycle pop.
  - Simultaneous push and pop (count < depth) leaves count unchanged; data ordering is strict FIFO.
  - Read and write pointers wrap modulo depth.
- oPianoCommand is held between issues. Repeated writes of the same value are harmless to the downstream block.
- States:
  - IDLE: if FIFO non-empty and !iPause, pop on this edge and load oPianoCommand <= event[15:8].
    - If dur==0: stay in IDLE, so the next event may pop on the following edge (one command per cycle).
    - If dur>0: go to WAIT with remaining <= dur and tick counter <= 0.
  - WAIT: while !iPause, the tick counter increments.
    - At TICK_DIV-1 the counter wraps to 0 and remaining decrements.
    - When remaining reaches 0, go to IDLE.
    - A duration d therefore occupies exactly d*TICK_DIV cycles in WAIT.
    - While iPause=1, the counter and remaining are frozen.
  - SILENCE: emits 8'h00, 8'h40, 8'h80, 8'hC0 on four consecutive edges (index 0..3), then goes to IDLE.
    - oPianoCommand holds 8'hC0 afterwards.
    - iPause does not freeze SILENCE.
- Latency: an event pushed at edge k into an empty FIFO with the sequencer in IDLE appears on oPianoCommand after edge k+1.
- iStop has highest priority and acts from any state:
  - FIFO flushed (count=0, pointers reset).
  - A push in the same cycle is dropped.
  - Tick counter and remaining cleared.
  - Enters SILENCE at index 0; the first silence command is visible after the next edge.
  - iStop during SILENCE restarts the sequence at index 0.
- iPause in IDLE blocks pops; queued events remain.
- oBusy and oFifoCount are registered/derived from current state and count, with no combinational path from inputs.
- Reset mid-operation (any state) returns immediately to the reset values above.

Test Plan (TICK_DIV=4, FIFO_AW=2):
- Push {8'h05,8'd2} at edge 1 → oPianoCommand=8'h05 after edge 2. It holds 8 cycles; oBusy drops and IDLE is re-entered after edge 10.
- Push {8'h05,0},{8'h47,0},{8'h89,1} back-to-back → oPianoCommand=05, 47, 89 on three consecutive cycles; then a 4-cycle WAIT.
- Push 5 events with the sequencer paused → fourth accepted with count=4 and oPushReady=0; fifth dropped; release pause → exactly 4 commands issued in order.
- Mid-WAIT of {8'h10,8'd3}, assert iPause for 6 cycles → WAIT total = 12+6 cycles; command unchanged throughout.
- With 3 events queued and one playing, pulse iStop → oFifoCount=0 next cycle; oPianoCommand sequence 00, 40, 80, C0; then IDLE with oBusy=0.
- Assert iFpgaReset asynchronously mid-WAIT → outputs return to reset values without waiting for a clock edge; a subsequent push plays normally.
